clock_set_ctrl: RTL and testbench
=================================

Name: clock_set_ctrl

Overview:
- Mode/set controller for the digital clock's seconds, minutes and hours counter chain.
- In RUN mode it converts a 1 Hz tick into cascaded per-counter enables.
- In the set modes it freezes timekeeping and drives synchronous load/digit strobes so the user can set hours and minutes with two debounced buttons.
- It sits between the button/prescaler logic and the three modulo counters.

Parameters:
SEC_MOD, 60, seconds counter modulo
MIN_MOD, 60, minutes counter modulo
HOUR_MOD, 24, hours counter modulo
VAL_W, 6, width of counter value inputs and load_digit; must satisfy 2^VAL_W >= max modulo

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
tick_1hz  input  1  one-clk-wide pulse, once per second
btn_mode  input  1  debounced mode button, level, synchronous to clk
btn_inc  input  1  debounced increment button, level, synchronous to clk
sec_val  input  VAL_W  current seconds counter value
min_val  input  VAL_W  current minutes counter value
hour_val  input  VAL_W  current hours counter value
sec_en  output  1  count enable pulse to seconds counter
min_en  output  1  count enable pulse to minutes counter
hour_en  output  1  count enable pulse to hours counter
sec_load  output  1  load strobe to seconds counter
min_load  output  1  load strobe to minutes counter
hour_load  output  1  load strobe to hours counter
load_digit  output  VAL_W  value presented with any load strobe
mode  output  2  0=RUN, 1=SET_HR, 2=SET_MIN
blink  output  1  display blink enable for the field being set

Behaviour:
- All outputs are registered. On reset: mode=RUN, all en/load=0, load_digit=0, blink=0, edge-detect history=0. Reset mid-operation aborts any set in progress; no load is issued.
- Button edges: mode_press = btn_mode & ~btn_mode_q, and the same for inc_press. History registers update every clk.
- Response latency: 1 clk. A press or tick sampled at edge N drives its outputs high for exactly 1 clk after edge N+1.
- FSM, evaluated on each press:
  - RUN + mode_press -> SET_HR.
  - SET_HR + mode_press -> SET_MIN.
  - SET_MIN + mode_press -> RUN, with sec_load=1 and load_digit=0, so seconds restart at 00.
  - mode=3 is illegal; it recovers to RUN on the next clk with no strobes.
- RUN + tick_1hz:
  - sec_en=1.
  - min_en=1 iff sec_val==SEC_MOD-1.
  - hour_en=1 iff additionally min_val==MIN_MOD-1.
- SET_HR / SET_MIN:
  - tick_1hz never raises any en output.
  - Each tick toggles blink; blink is forced to 0 on entry to RUN and on entry to each set state.
- SET_HR + inc_press: hour_load=1, load_digit = (hour_val>=HOUR_MOD-1) ? 0 : hour_val+1.
- SET_MIN + inc_press: min_load=1, load_digit = (min_val>=MIN_MOD-1) ? 0 : min_val+1. Out-of-range inputs also wrap to 0.
- inc_press in RUN is ignored.
- Simultaneous events:
  - mode_press and inc_press in the same cycle: mode wins, inc is dropped.
  - tick and inc in a set state: load issued, blink still toggles.
  - tick and mode_press leaving RUN: the tick is still honoured (en pulses issued) and the state changes.
- At most one load strobe is high in any cycle. en and load are never high together.
- A held button yields one press only. Re-press requires a low cycle.

Test Plan:
- Reset held, then released in RUN; pulse tick_1hz with sec_val=12 -> one cycle later sec_en=1, min_en=0, hour_en=0, all loads 0, mode=0.
- RUN, sec_val=59, min_val=59, hour_val=23, tick -> sec_en=min_en=hour_en=1 for exactly one clk.
- Press mode -> mode=1. hour_val=23, press inc -> hour_load=1, load_digit=0. hour_val=7, press inc -> load_digit=8. Ticks give no en pulses and blink toggles per tick.
- Press mode twice from SET_HR -> mode=2, then mode=0 with sec_load=1, load_digit=0 on the exit cycle. min_val=59 inc in SET_MIN -> load_digit=0.
- btn_mode and btn_inc rise on the same clk in SET_HR -> mode=2, no hour_load. btn_inc held 10 clks -> exactly one load.
- Assert reset during SET_MIN, async, between clock edges -> outputs and mode=0 immediately. After release, tick gives normal RUN enables.

Source files
------------

// File: rtl/clock_set_ctrl.sv
// Mode/set controller for the seconds/minutes/hours counter chain.
// Inputs are captured in one event stage; the FSM acts on that stage one clk later.
module clock_set_ctrl #(
    parameter int SEC_MOD  = 60,
    parameter int MIN_MOD  = 60,
    parameter int HOUR_MOD = 24,
    parameter int VAL_W    = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick_1hz,
    input  logic             btn_mode,
    input  logic             btn_inc,
    input  logic [VAL_W-1:0] sec_val,
    input  logic [VAL_W-1:0] min_val,
    input  logic [VAL_W-1:0] hour_val,
    output logic             sec_en,
    output logic             min_en,
    output logic             hour_en,
    output logic             sec_load,
    output logic             min_load,
    output logic             hour_load,
    output logic [VAL_W-1:0] load_digit,
    output logic [1:0]       mode,
    output logic             blink
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2,
        ILLEGAL = 2'd3
    } mode_t;

    typedef struct packed {
        logic             tick;
        logic             mode_p;
        logic             inc_p;
        logic [VAL_W-1:0] sec;
        logic [VAL_W-1:0] min;
        logic [VAL_W-1:0] hour;
    } evt_t;

    localparam logic [VAL_W-1:0] SEC_MAX  = VAL_W'(SEC_MOD - 1);
    localparam logic [VAL_W-1:0] MIN_MAX  = VAL_W'(MIN_MOD - 1);
    localparam logic [VAL_W-1:0] HOUR_MAX = VAL_W'(HOUR_MOD - 1);

    mode_t            state;
    evt_t             ev;
    logic             btn_mode_q;
    logic             btn_inc_q;

    // Increment with wrap; anything at or beyond the top value restarts at 0.
    function automatic logic [VAL_W-1:0] next_val(input logic [VAL_W-1:0] v,
                                                  input logic [VAL_W-1:0] vmax);
        return (v >= vmax) ? '0 : v + VAL_W'(1);
    endfunction

    assign mode = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_mode_q <= 1'b0;
            btn_inc_q  <= 1'b0;
            ev         <= '0;
        end else begin
            btn_mode_q <= btn_mode;
            btn_inc_q  <= btn_inc;
            ev.tick    <= tick_1hz;
            ev.mode_p  <= btn_mode & ~btn_mode_q;
            ev.inc_p   <= btn_inc & ~btn_inc_q;
            ev.sec     <= sec_val;
            ev.min     <= min_val;
            ev.hour    <= hour_val;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= RUN;
            sec_en     <= 1'b0;
            min_en     <= 1'b0;
            hour_en    <= 1'b0;
            sec_load   <= 1'b0;
            min_load   <= 1'b0;
            hour_load  <= 1'b0;
            load_digit <= '0;
            blink      <= 1'b0;
        end else begin
            sec_en    <= 1'b0;
            min_en    <= 1'b0;
            hour_en   <= 1'b0;
            sec_load  <= 1'b0;
            min_load  <= 1'b0;
            hour_load <= 1'b0;
            case (state)
                RUN: begin
                    // A tick coinciding with the mode press is still honoured.
                    if (ev.tick) begin
                        sec_en  <= 1'b1;
                        min_en  <= (ev.sec == SEC_MAX);
                        hour_en <= (ev.sec == SEC_MAX) && (ev.min == MIN_MAX);
                    end
                    blink <= 1'b0;
                    if (ev.mode_p) state <= SET_HR;
                end
                SET_HR: begin
                    if (ev.mode_p) begin
                        state <= SET_MIN;
                        blink <= 1'b0;
                    end else begin
                        if (ev.inc_p) begin
                            hour_load  <= 1'b1;
                            load_digit <= next_val(ev.hour, HOUR_MAX);
                        end
                        if (ev.tick) blink <= ~blink;
                    end
                end
                SET_MIN: begin
                    if (ev.mode_p) begin
                        state      <= RUN;
                        sec_load   <= 1'b1;
                        load_digit <= '0;
                        blink      <= 1'b0;
                    end else begin
                        if (ev.inc_p) begin
                            min_load   <= 1'b1;
                            load_digit <= next_val(ev.min, MIN_MAX);
                        end
                        if (ev.tick) blink <= ~blink;
                    end
                end
                default: begin
                    state <= RUN;
                    blink <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl: run enables, set modes, simultaneous events, async reset.
module tb_clock_set_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick_1hz = 1'b0, btn_mode = 1'b0, btn_inc = 1'b0;
    logic [5:0] sec_val = '0, min_val = '0, hour_val = '0;
    logic       sec_en, min_en, hour_en, sec_load, min_load, hour_load, blink;
    logic [5:0] load_digit;
    logic [1:0] mode;
    logic [6:0] o;
    int         tests = 0, fails = 0;

    // {sec_en,min_en,hour_en,sec_load,min_load,hour_load,blink}
    assign o = {sec_en, min_en, hour_en, sec_load, min_load, hour_load, blink};

    clock_set_ctrl #(.SEC_MOD(60), .MIN_MOD(60), .HOUR_MOD(24), .VAL_W(6)) dut (
        .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .btn_mode(btn_mode),
        .btn_inc(btn_inc), .sec_val(sec_val), .min_val(min_val), .hour_val(hour_val),
        .sec_en(sec_en), .min_en(min_en), .hour_en(hour_en), .sec_load(sec_load),
        .min_load(min_load), .hour_load(hour_load), .load_digit(load_digit),
        .mode(mode), .blink(blink)
    );

    always #5 clk = ~clk;

    // Drive inputs for one cycle starting at a falling edge; returns at the next falling edge.
    task automatic drive(input logic t, input logic m, input logic i);
        @(negedge clk);
        tick_1hz = t; btn_mode = m; btn_inc = i;
        @(negedge clk);
        tick_1hz = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
    endtask

    task automatic settle;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (o !== 7'b0) begin fails++; $display("FAIL reset_strobes got %b want 0000000", o); end
        tests++; if (mode !== 2'd0) begin fails++; $display("FAIL reset_mode got %0d want 0", mode); end
        tests++; if (load_digit !== 6'd0) begin fails++; $display("FAIL reset_digit got %0d want 0", load_digit); end
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_run_tick;
        sec_val = 6'd12; min_val = 6'd30; hour_val = 6'd5;
        drive(1'b1, 1'b0, 1'b0); settle;
        tests++; if (o !== 7'b1000000 || mode !== 2'd0) begin fails++; $display("FAIL run_tick got %b mode %0d want 1000000 mode 0", o, mode); end
        settle;
        tests++; if (o !== 7'b0) begin fails++; $display("FAIL run_tick_clear got %b want 0000000", o); end
        drive(1'b0, 1'b0, 1'b1); settle;
        tests++; if (o !== 7'b0 || mode !== 2'd0) begin fails++; $display("FAIL run_inc_ignored got %b mode %0d want 0000000 mode 0", o, mode); end
    endtask

    task automatic test_cascade;
        sec_val = 6'd59; min_val = 6'd59; hour_val = 6'd23;
        drive(1'b1, 1'b0, 1'b0); settle;
        tests++; if (o !== 7'b1110000) begin fails++; $display("FAIL cascade got %b want 1110000", o); end
        settle;
        tests++; if (o !== 7'b0) begin fails++; $display("FAIL cascade_clear got %b want 0000000", o); end
        sec_val = 6'd59; min_val = 6'd10;
        drive(1'b1, 1'b0, 1'b0); settle;
        tests++; if (o !== 7'b1100000) begin fails++; $display("FAIL cascade_min got %b want 1100000", o); end
    endtask

    task automatic test_set_hr;
        drive(1'b0, 1'b1, 1'b0); settle;
        tests++; if (mode !== 2'd1 || o !== 7'b0) begin fails++; $display("FAIL enter_hr mode %0d out %b want 1 0000000", mode, o); end
        hour_val = 6'd23;
        drive(1'b0, 1'b0, 1'b1); settle;
        tests++; if (o !== 7'b0000010 || load_digit !== 6'd0) begin fails++; $display("FAIL hr_wrap out %b digit %0d want 0000010 0", o, load_digit); end
        settle;
        tests++; if (hour_load !== 1'b0) begin fails++; $display("FAIL hr_load_width got %b want 0", hour_load); end
        hour_val = 6'd7;
        drive(1'b0, 1'b0, 1'b1); settle;
        tests++; if (o !== 7'b0000010 || load_digit !== 6'd8) begin fails++; $display("FAIL hr_inc out %b digit %0d want 0000010 8", o, load_digit); end
        sec_val = 6'd59; min_val = 6'd59;
        drive(1'b1, 1'b0, 1'b0); settle;
        tests++; if (o !== 7'b0000001) begin fails++; $display("FAIL hr_tick1 got %b want 0000001", o); end
        drive(1'b1, 1'b0, 1'b0); settle;
        tests++; if (o !== 7'b0000000) begin fails++; $display("FAIL hr_tick2 got %b want 0000000", o); end
        hour_val = 6'd30;
        drive(1'b0, 1'b0, 1'b1); settle;
        tests++; if (hour_load !== 1'b1 || load_digit !== 6'd0) begin fails++; $display("FAIL hr_oor load %b digit %0d want 1 0", hour_load, load_digit); end
    endtask

    task automatic test_set_min;
        drive(1'b1, 1'b0, 1'b0); settle;   // blink=1 before leaving SET_HR
        drive(1'b0, 1'b1, 1'b0); settle;
        tests++; if (mode !== 2'd2 || o !== 7'b0) begin fails++; $display("FAIL enter_min mode %0d out %b want 2 0000000", mode, o); end
        min_val = 6'd59;
        drive(1'b0, 1'b0, 1'b1); settle;
        tests++; if (o !== 7'b0000100 || load_digit !== 6'd0) begin fails++; $display("FAIL min_wrap out %b digit %0d want 0000100 0", o, load_digit); end
        min_val = 6'd30;
        drive(1'b0, 1'b0, 1'b1); settle;
        tests++; if (o !== 7'b0000100 || load_digit !== 6'd31) begin fails++; $display("FAIL min_inc out %b digit %0d want 0000100 31", o, load_digit); end
        drive(1'b0, 1'b1, 1'b0); settle;
        tests++; if (mode !== 2'd0 || o !== 7'b0001000 || load_digit !== 6'd0) begin fails++; $display("FAIL exit_min mode %0d out %b digit %0d want 0 0001000 0", mode, o, load_digit); end
        settle;
        tests++; if (o !== 7'b0) begin fails++; $display("FAIL exit_clear got %b want 0000000", o); end
    endtask

    task automatic test_simultaneous;
        int n;
        drive(1'b0, 1'b1, 1'b0); settle;   // RUN -> SET_HR
        @(negedge clk); btn_mode = 1'b1; btn_inc = 1'b1;
        @(negedge clk); btn_mode = 1'b0;
        settle;
        tests++; if (mode !== 2'd2 || hour_load !== 1'b0 || min_load !== 1'b0) begin fails++; $display("FAIL mode_wins mode %0d hl %b ml %b want 2 0 0", mode, hour_load, min_load); end
        n = 0;
        repeat (8) begin settle; if (min_load) n++; end
        tests++; if (n !== 0) begin fails++; $display("FAIL held_from_combo got %0d loads want 0", n); end
        @(negedge clk); btn_inc = 1'b0;
        @(negedge clk); btn_inc = 1'b1;
        n = 0;
        repeat (10) begin settle; if (min_load) n++; end
        @(negedge clk); btn_inc = 1'b0;
        repeat (3) begin settle; if (min_load) n++; end
        tests++; if (n !== 1) begin fails++; $display("FAIL held_one_press got %0d loads want 1", n); end
        drive(1'b0, 1'b1, 1'b0); settle;   // back to RUN
        tests++; if (mode !== 2'd0 || sec_load !== 1'b1) begin fails++; $display("FAIL simul_exit mode %0d sl %b want 0 1", mode, sec_load); end
    endtask

    task automatic test_back_to_back;
        sec_val = 6'd59; min_val = 6'd10; hour_val = 6'd3;
        drive(1'b1, 1'b1, 1'b0); settle;
        tests++; if (o !== 7'b1100000 || mode !== 2'd1) begin fails++; $display("FAIL tick_mode out %b mode %0d want 1100000 1", o, mode); end
        drive(1'b1, 1'b0, 1'b1); settle;
        tests++; if (o !== 7'b0000011 || load_digit !== 6'd4) begin fails++; $display("FAIL tick_inc out %b digit %0d want 0000011 4", o, load_digit); end
        drive(1'b1, 1'b1, 1'b0); settle;
        tests++; if (o !== 7'b0 || mode !== 2'd2) begin fails++; $display("FAIL tick_mode_hr out %b mode %0d want 0000000 2", o, mode); end
    endtask

    task automatic test_async_reset;
        tests++; if (mode !== 2'd2) begin fails++; $display("FAIL pre_reset_mode got %0d want 2", mode); end
        drive(1'b1, 1'b0, 1'b0); settle;   // blink=1 in SET_MIN
        @(negedge clk); #2 reset = 1'b1; #1;
        tests++; if (o !== 7'b0 || mode !== 2'd0 || load_digit !== 6'd0) begin fails++; $display("FAIL async_reset out %b mode %0d digit %0d want 0000000 0 0", o, mode, load_digit); end
        @(negedge clk); reset = 1'b0;
        sec_val = 6'd5; min_val = 6'd59;
        drive(1'b1, 1'b0, 1'b0); settle;
        tests++; if (o !== 7'b1000000 || mode !== 2'd0) begin fails++; $display("FAIL post_reset_tick out %b mode %0d want 1000000 0", o, mode); end
    endtask

    initial begin
        test_reset;
        test_run_tick;
        test_cascade;
        test_set_hr;
        test_set_min;
        test_simultaneous;
        test_back_to_back;
        test_async_reset;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
